// File: rtl/lc3_pkg.sv
// LC-3 load/store unit shared definitions.
// Op encodings, FSM states and default user-space bounds.
package lc3_pkg;

  localparam logic [1:0] OP_LD  = 2'b00;
  localparam logic [1:0] OP_ST  = 2'b01;
  localparam logic [1:0] OP_LDI = 2'b10;
  localparam logic [1:0] OP_STI = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PTR,
    S_ACC,
    S_FIN
  } state_t;

  localparam logic [15:0] ACV_LO_DEF = 16'h3000;
  localparam logic [15:0] ACV_HI_DEF = 16'hFE00;

endpackage

// File: rtl/lc3_acv_check.sv
// LC-3 user-mode address range comparator.
// Flags user accesses outside [LO, HI).
module lc3_acv_check
  import lc3_pkg::*;
#(
  parameter int                ADDR_W = 16,
  parameter logic [ADDR_W-1:0] LO     = ADDR_W'(ACV_LO_DEF),
  parameter logic [ADDR_W-1:0] HI     = ADDR_W'(ACV_HI_DEF)
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              user_mode,
  output logic              violation
);

  assign violation = user_mode &&
                     ((addr < LO) || (addr >= HI));

endmodule

// File: rtl/lc3_mem_access.sv
// LC-3 load/store unit: LD/ST/LDI/STI over a req/ack port.
// Optional access-violation check: define LC3_MEM_ACV_EN.
module lc3_mem_access
  import lc3_pkg::*;
#(
  parameter int                ADDR_W = 16,
  parameter int                DATA_W = 16,
  parameter logic [ADDR_W-1:0] ACV_LO = ADDR_W'(ACV_LO_DEF),
  parameter logic [ADDR_W-1:0] ACV_HI = ADDR_W'(ACV_HI_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic              user_mode,
  output logic              busy,
  output logic              done,
  output logic              acv,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic              viol_q, viol_d;
  logic              acv_q, acv_d;
  logic              req_d, we_d;
  logic [ADDR_W-1:0] maddr_d;
  logic [DATA_W-1:0] mwdata_d, mdata_d;
  logic [ADDR_W-1:0] ea;
  logic              ack_ok, ind;
  logic              v_start, v_ptr;

  assign ack_ok = mem_ack & mem_req;
  assign ind    = (op == OP_LDI) || (op == OP_STI);
  assign ea     = ADDR_W'(mem_rdata);
  assign busy   = (state_q == S_PTR) || (state_q == S_ACC);
  assign done   = (state_q == S_FIN);

`ifdef LC3_MEM_ACV_EN
  logic user_q;

  lc3_acv_check #(
    .ADDR_W (ADDR_W),
    .LO     (ACV_LO),
    .HI     (ACV_HI)
  ) u_chk_start (
    .addr      (addr),
    .user_mode (user_mode),
    .violation (v_start)
  );

  lc3_acv_check #(
    .ADDR_W (ADDR_W),
    .LO     (ACV_LO),
    .HI     (ACV_HI)
  ) u_chk_ptr (
    .addr      (ea),
    .user_mode (user_q),
    .violation (v_ptr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      user_q <= 1'b0;
    else if (state_q == S_IDLE && start)
      user_q <= user_mode;
  end

  assign acv = acv_q;
`else
  logic unused_sink;

  assign v_start     = 1'b0;
  assign v_ptr       = 1'b0;
  assign acv         = 1'b0;
  assign unused_sink = ^{user_mode, acv_q,
                         ACV_LO, ACV_HI};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    viol_d   = viol_q;
    acv_d    = 1'b0;
    req_d    = mem_req;
    we_d     = mem_we;
    maddr_d  = mem_addr;
    mwdata_d = mem_wdata;
    mdata_d  = mem_data;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d     = op;
          mwdata_d = st_data;
          viol_d   = v_start;
          maddr_d  = addr;
          // a violating start still burns one quiet busy cycle
          if (v_start) begin
            state_d = S_ACC;
            req_d   = 1'b0;
            we_d    = 1'b0;
          end else if (ind) begin
            state_d = S_PTR;
            req_d   = 1'b1;
            we_d    = 1'b0;
          end else begin
            state_d = S_ACC;
            req_d   = 1'b1;
            we_d    = op[0];
          end
        end
      end
      S_PTR: begin
        if (ack_ok) begin
          if (v_ptr) begin
            state_d = S_FIN;
            req_d   = 1'b0;
            we_d    = 1'b0;
            acv_d   = 1'b1;
          end else begin
            state_d = S_ACC;
            maddr_d = ea;
            we_d    = op_q[0];
          end
        end
      end
      S_ACC: begin
        if (viol_q) begin
          state_d = S_FIN;
          viol_d  = 1'b0;
          acv_d   = 1'b1;
        end else if (ack_ok) begin
          state_d = S_FIN;
          req_d   = 1'b0;
          we_d    = 1'b0;
          if (!op_q[0])
            mdata_d = mem_rdata;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= 2'b00;
      viol_q    <= 1'b0;
      acv_q     <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_data  <= '0;
    end else begin
      op_q      <= op_d;
      viol_q    <= viol_d;
      acv_q     <= acv_d;
      mem_req   <= req_d;
      mem_we    <= we_d;
      mem_addr  <= maddr_d;
      mem_wdata <= mwdata_d;
      mem_data  <= mdata_d;
    end
  end

endmodule

// File: tb/tb_lc3_mem_access.sv
// Randomized self-checking bench for lc3_mem_access.
// Reference model: per-op expected request phases and results.
module tb_lc3_mem_access;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [15:0] addr = '0;
  logic [15:0] st_data = '0;
  logic        user_mode = 1'b0;
  logic        busy, done, acv;
  logic [15:0] mem_data;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  logic [15:0] mem [65536];
  logic [15:0] md_model = '0;
  int          n_tests = 0;
  int          n_fail = 0;

  lc3_mem_access dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .addr      (addr),
    .st_data   (st_data),
    .user_mode (user_mode),
    .busy      (busy),
    .done      (done),
    .acv       (acv),
    .mem_data  (mem_data),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic bit is_viol(input logic [15:0] a,
                                 input logic um);
`ifdef LC3_MEM_ACV_EN
    return um && (a < 16'h3000 || a >= 16'hFE00);
`else
    return 1'b0;
`endif
  endfunction

  task automatic noise();
    start     = 1'($urandom);
    op        = 2'($urandom);
    addr      = 16'($urandom);
    st_data   = 16'($urandom);
    user_mode = 1'($urandom);
  endtask

  task automatic run_op(input logic [1:0]  o,
                        input logic [15:0] a,
                        input logic [15:0] d,
                        input logic        um,
                        input int          w0,
                        input int          w1);
    int          nph, ph, w, writes, exp_writes;
    int          exp_done;
    logic [15:0] pa [2];
    logic        pw [2];
    int          ws [2];
    logic [15:0] ptr;
    bit          ex_acv, fin;
    ws[0] = w0;
    ws[1] = w1;
    ptr = mem[a];
    ex_acv = 1'b0;
    pa[0] = a;
    pa[1] = ptr;
    pw[0] = o[1] ? 1'b0 : o[0];
    pw[1] = o[0];
    if (is_viol(a, um)) begin
      nph = 0;
      ex_acv = 1'b1;
    end else if (!o[1]) begin
      nph = 1;
    end else if (is_viol(ptr, um)) begin
      nph = 1;
      ex_acv = 1'b1;
    end else begin
      nph = 2;
    end
    exp_done = 1;
    for (int i = 0; i < nph; i++)
      exp_done += ws[i] + 1;
    if (nph == 0)
      exp_done = 2;
    exp_writes = (!ex_acv && o[0]) ? 1 : 0;
    if (!ex_acv && !o[0])
      md_model = o[1] ? mem[ptr] : mem[a];

    @(negedge clk);
    start = 1'b1;
    op = o;
    addr = a;
    st_data = d;
    user_mode = um;
    mem_ack = 1'b0;
    ph = 0;
    w = 0;
    writes = 0;
    fin = 1'b0;
    for (int cyc = 1; cyc <= 80 && !fin; cyc++) begin
      @(negedge clk);
      noise();
      if (done) begin
        fin = 1'b1;
        check("done_cyc", cyc, exp_done);
        check("acv", acv, ex_acv);
        check("busy_fin", busy, 0);
        check("phases", ph, nph);
        check("writes", writes, exp_writes);
        check("mem_data", mem_data, md_model);
        mem_ack = 1'($urandom);
        mem_rdata = 16'($urandom);
      end else begin
        check("busy", busy, 1);
        if (mem_req && ph >= nph) begin
          check("extra_req", mem_req, 0);
          mem_ack = 1'b0;
        end else if (mem_req) begin
          check("addr", mem_addr, pa[ph]);
          check("we", mem_we, pw[ph]);
          if (pw[ph])
            check("wdata", mem_wdata, d);
          if (w >= ws[ph]) begin
            mem_ack = 1'b1;
            if (mem_we) begin
              mem[mem_addr] = mem_wdata;
              writes++;
            end else begin
              mem_rdata = mem[mem_addr];
            end
            ph++;
            w = 0;
          end else begin
            mem_ack = 1'b0;
            mem_rdata = 16'($urandom);
            w++;
          end
        end else begin
          mem_ack = 1'($urandom);
          mem_rdata = 16'($urandom);
        end
      end
    end
    if (!fin)
      check("timeout", done, 1);
    @(negedge clk);
    start = 1'b0;
    check("done_pulse", done, 0);
    check("idle_busy", busy, 0);
    check("md_hold", mem_data, md_model);
    mem_ack = 1'($urandom);
    mem_rdata = 16'($urandom);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++)
      mem[i] = 16'($urandom);

    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_acv", acv, 0);
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_mdata", mem_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ack = 1'b1;
    @(negedge clk);
    check("spur_ack", busy, 0);
    mem_ack = 1'b0;

    mem[16'h3050] = 16'hBEEF;
    run_op(2'b00, 16'h3050, 16'h0000, 1'b0, 0, 0);
    check("ld_beef", mem_data, 16'hBEEF);

    run_op(2'b01, 16'h4000, 16'h1234, 1'b0, 3, 0);
    check("st_mem", mem[16'h4000], 16'h1234);
    check("st_md", mem_data, 16'hBEEF);

    mem[16'h3000] = 16'h5000;
    mem[16'h5000] = 16'hA5A5;
    run_op(2'b10, 16'h3000, 16'h0000, 1'b0, 0, 0);
    check("ldi_a5", mem_data, 16'hA5A5);

    mem[16'h3100] = 16'h6000;
    run_op(2'b11, 16'h3100, 16'h7777, 1'b0, 1, 2);
    check("sti_mem", mem[16'h6000], 16'h7777);

    @(negedge clk);
    start = 1'b1;
    op = 2'b00;
    addr = 16'h3200;
    user_mode = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("pre_rst_req", mem_req, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_req", mem_req, 0);
    check("abort_busy", busy, 0);
    repeat (2) begin
      @(negedge clk);
      check("abort_done", done, 0);
    end
    rst_n = 1'b1;
    md_model = '0;
    @(negedge clk);
    check("abort_md", mem_data, 0);
    mem[16'h3200] = 16'hC0DE;
    run_op(2'b00, 16'h3200, 16'h0000, 1'b0, 2, 0);
    check("post_rst_ld", mem_data, 16'hC0DE);

    for (int k = 0; k < 80; k++)
      run_op(2'($urandom), 16'($urandom), 16'($urandom),
             1'($urandom), $urandom_range(0, 3),
             $urandom_range(0, 3));

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
